// File: rtl/scan_mux_n_if.sv
// scan_mux_n_if: digit data in, segment/anode pins out.
// master = digit encoder side, slave = scanner.
interface scan_mux_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7*NUM_DIGITS-1:0] digit_seg;
  logic [NUM_DIGITS-1:0]   digit_dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output digit_seg, digit_dp, digit_en, brightness,
    input  seg, an, frame_tick
  );

  modport slave (
    input  digit_seg, digit_dp, digit_en, brightness,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/scan_mux_n.sv
// scan_mux_n: N-digit 7-seg scanner, PWM brightness, frame snapshots.
// Option: SCAN_GHOST_GUARD_EN blanks the first cycle of every digit slot.
module scan_mux_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int PRE_W      = 16
) (
  input logic         clk,
  input logic         reset,
  scan_mux_n_if.slave bus
);
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam int SW = 7 * NUM_DIGITS;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [3:0]            sub_q, sub_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SW-1:0]         sh_seg_q, sh_seg_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d;
  logic [3:0]            sh_bri_q, sh_bri_d;
  logic                  load_pend_q, load_pend_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  ft_q, ft_d;

  logic                  pre_wrap;
  logic                  sub_wrap;
  logic                  idx_last;
  logic                  fe;
  logic                  load;
  logic                  cur_en;
  logic                  cur_dp;
  logic [6:0]            cur_seg;
  logic                  lit;

  // Prescaler, sub-slot and digit index advance.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    sub_wrap = (sub_q == 4'hF);
    idx_last = (idx_q == IDX_LAST);
    fe       = pre_wrap && sub_wrap && idx_last;
    pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
    sub_d    = sub_q;
    if (pre_wrap) sub_d = sub_q + 4'd1;
    idx_d    = idx_q;
    if (pre_wrap && sub_wrap) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow capture at frame end or on the first edge after reset.
  always_comb begin
    load        = fe || load_pend_q;
    sh_seg_d    = sh_seg_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    sh_bri_d    = sh_bri_q;
    load_pend_d = 1'b0;
    if (load) begin
      sh_seg_d = bus.digit_seg;
      sh_dp_d  = bus.digit_dp;
      sh_en_d  = bus.digit_en;
      sh_bri_d = bus.brightness;
    end
  end

  // Select the active digit's shadow data and decide if it lights.
  always_comb begin
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    cur_seg = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_en  = sh_en_q[i];
        cur_dp  = sh_dp_q[i];
        cur_seg = sh_seg_q[7*i +: 7];
      end
    end
    lit = cur_en && (sub_q <= sh_bri_q);
`ifdef SCAN_GHOST_GUARD_EN
    if (pre_q == '0 && sub_q == 4'd0) lit = 1'b0;
`endif
  end

  // Next pin state: one anode low while lit, else all dark.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    ft_d  = fe;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
      seg_d = {~cur_dp, cur_seg};
    end
  end

  // State and output registers; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      sub_q       <= '0;
      idx_q       <= '0;
      sh_seg_q    <= '1;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      sh_bri_q    <= '0;
      load_pend_q <= 1'b1;
      an_q        <= '1;
      seg_q       <= 8'hFF;
      ft_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      sh_seg_q    <= sh_seg_d;
      sh_dp_q     <= sh_dp_d;
      sh_en_q     <= sh_en_d;
      sh_bri_q    <= sh_bri_d;
      load_pend_q <= load_pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      ft_q        <= ft_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// tb_scan_mux_n: two configs (4 digits/prescale 2, 3 digits/prescale 1)
// checked every cycle against a position-based model plus literals.
module tb_scan_mux_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef SCAN_GHOST_GUARD_EN
  localparam bit GG = 1'b1;
`else
  localparam bit GG = 1'b0;
`endif

  logic [55:0] in_seg [2];
  logic [7:0]  in_dp  [2];
  logic [7:0]  in_en  [2];
  logic [3:0]  in_bri [2];

  int n_chk = 0;
  int n_err = 0;
  int k = -1;
  int ph = 0;
  bit ran = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N  = (g == 0) ? 4 : 3;
    localparam int P  = (g == 0) ? 2 : 1;
    localparam int FL = N * 16 * P;

    scan_mux_n_if #(.NUM_DIGITS(N)) bus ();

    scan_mux_n #(
      .NUM_DIGITS(N),
      .PRESCALE(P),
      .PRE_W(16)
    ) dut (
      .clk(clk),
      .reset(rst),
      .bus(bus)
    );

    assign bus.digit_seg  = in_seg[g][7*N-1:0];
    assign bus.digit_dp   = in_dp[g][N-1:0];
    assign bus.digit_en   = in_en[g][N-1:0];
    assign bus.brightness = in_bri[g];

    wire [7:0] a_an = {{(8-N){1'b1}}, bus.an};

    logic [7:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft;
    logic [6:0] s_seg [8];
    logic [7:0] s_en;
    logic [7:0] s_dp;
    int         s_bri;
    int         pos;
    bit         val;
    bit         pend;

    // Model: position within frame decides digit, sub-slot and duty.
    initial begin
      int d;
      int sb;
      int pr;
      bit lt;
      forever begin
        @(posedge clk);
        if (rst) begin
          pos = 0; val = 1'b0; pend = 1'b1;
          e_an = 8'hFF; e_seg = 8'hFF; e_ft = 1'b0;
        end else begin
          d  = pos / (16 * P);
          sb = (pos / P) % 16;
          pr = pos % P;
          lt = val && s_en[d] && (sb <= s_bri);
          if (GG && pr == 0 && sb == 0) lt = 1'b0;
          e_an  = 8'hFF;
          e_seg = 8'hFF;
          if (lt) begin
            e_an[d] = 1'b0;
            e_seg   = {~s_dp[d], s_seg[d]};
          end
          e_ft = (pos == FL - 1);
          if (pend || e_ft) begin
            for (int i = 0; i < N; i++) begin
              s_seg[i] = in_seg[g][7*i +: 7];
            end
            s_en  = in_en[g];
            s_dp  = in_dp[g];
            s_bri = int'(in_bri[g]);
            val   = 1'b1;
            pend  = 1'b0;
          end
          pos = (pos + 1) % FL;
        end
      end
    end
  end

  task automatic cmp(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d ph=%0d: got %h want %h",
               nm, k, ph, act, exp);
    end
  endtask

  // Compare on falling edges, away from the DUT's active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ran) ph = 1;
        k = -1;
      end else begin
        k++;
        if (k >= 1) ran = 1'b1;
      end
      cmp("A.an",  u[0].a_an,              u[0].e_an);
      cmp("A.seg", u[0].bus.seg,           u[0].e_seg);
      cmp("A.ft",  {7'd0, u[0].bus.frame_tick}, {7'd0, u[0].e_ft});
      cmp("B.an",  u[1].a_an,              u[1].e_an);
      cmp("B.seg", u[1].bus.seg,           u[1].e_seg);
      cmp("B.ft",  {7'd0, u[1].bus.frame_tick}, {7'd0, u[1].e_ft});
      if (ph == 0) begin
        case (k)
          1: begin
            cmp("L.A.an1",  u[0].a_an,    8'hFE);
            cmp("L.A.seg1", u[0].bus.seg, 8'hC0);
            cmp("L.B.an1",  u[1].a_an,    8'hFE);
            cmp("L.B.seg1", u[1].bus.seg, 8'h81);
          end
          16: cmp("L.B.gap", u[1].a_an, GG ? 8'hFF : 8'hFD);
          22: cmp("L.B.duty", u[1].a_an, 8'hFF);
          33: begin
            cmp("L.A.an33",  u[0].a_an,    8'hFD);
            cmp("L.A.seg33", u[0].bus.seg, 8'hF9);
            cmp("L.B.an33",  u[1].a_an,    8'hFB);
            cmp("L.B.seg33", u[1].bus.seg, 8'h84);
          end
          46: cmp("L.B.ft46", {7'd0, u[1].bus.frame_tick}, 8'd0);
          47: cmp("L.B.ft47", {7'd0, u[1].bus.frame_tick}, 8'd1);
          65: begin
            cmp("L.A.an65",  u[0].a_an,    8'hFB);
            cmp("L.A.seg65", u[0].bus.seg, 8'hA4);
          end
          97: begin
            cmp("L.A.an97",  u[0].a_an,    8'hF7);
            cmp("L.A.seg97", u[0].bus.seg, 8'hB0);
          end
          126: cmp("L.A.ft126", {7'd0, u[0].bus.frame_tick}, 8'd0);
          127: cmp("L.A.ft127", {7'd0, u[0].bus.frame_tick}, 8'd1);
          129: begin
            cmp("L.A.an129",  u[0].a_an,    8'hFE);
            cmp("L.A.seg129", u[0].bus.seg, 8'h92);
          end
          135: cmp("L.A.an135", u[0].a_an, 8'hFE);
          136: begin
            cmp("L.A.an136",  u[0].a_an,    8'hFF);
            cmp("L.A.seg136", u[0].bus.seg, 8'hFF);
          end
          161: cmp("L.A.seg161", u[0].bus.seg, 8'hF9);
          168: cmp("L.A.an168", u[0].a_an, 8'hFF);
          240: cmp("L.B.an240", u[1].a_an, GG ? 8'hFF : 8'hFE);
          241: cmp("L.B.an241", u[1].a_an, 8'hFF);
          255: cmp("L.A.ft255", {7'd0, u[0].bus.frame_tick}, 8'd1);
          257: begin
            cmp("L.A.an257",  u[0].a_an,    8'hFF);
            cmp("L.A.seg257", u[0].bus.seg, 8'hFF);
          end
          290: begin
            cmp("L.A.an290",  u[0].a_an,    8'hFD);
            cmp("L.A.seg290", u[0].bus.seg, 8'h79);
          end
          322: cmp("L.A.an322", u[0].a_an, 8'hFF);
          354: begin
            cmp("L.A.an354",  u[0].a_an,    8'hF7);
            cmp("L.A.seg354", u[0].bus.seg, 8'hB0);
          end
          383: cmp("L.A.ft383", {7'd0, u[0].bus.frame_tick}, 8'd1);
          default: ;
        endcase
      end else begin
        case (k)
          -1: begin
            cmp("L.R.an",   u[0].a_an,    8'hFF);
            cmp("L.R.seg",  u[0].bus.seg, 8'hFF);
            cmp("L.R.ft",   {7'd0, u[0].bus.frame_tick}, 8'd0);
            cmp("L.R.Ban",  u[1].a_an,    8'hFF);
          end
          0: cmp("L.R.an0", u[0].a_an, 8'hFF);
          1: begin
            cmp("L.R.an1",  u[0].a_an,    8'hFE);
            cmp("L.R.seg1", u[0].bus.seg, 8'h92);
            cmp("L.R.Ban1", u[1].a_an,    8'hFF);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic at_k(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (n > 3000) begin
        $display("FAIL timeout waiting for k=%0d: got k=%0d", target, k);
        $fatal(1);
      end
    end while (k != target);
  endtask

  initial begin
    in_seg[0] = {28'd0, 7'h30, 7'h24, 7'h79, 7'h40};
    in_dp[0]  = 8'h00;
    in_en[0]  = 8'h0F;
    in_bri[0] = 4'd15;
    in_seg[1] = {35'd0, 7'h04, 7'h02, 7'h01};
    in_dp[1]  = 8'h00;
    in_en[1]  = 8'h07;
    in_bri[1] = 4'd5;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    at_k(50);
    in_seg[0][6:0] = 7'h12;
    in_bri[0]      = 4'd3;
    at_k(200);
    in_en[0]  = 8'h0A;
    in_dp[0]  = 8'h02;
    in_bri[0] = 4'd15;
    in_bri[1] = 4'd0;
    at_k(400);
    rst = 1'b1;
    in_en[0] = 8'h0F;
    in_dp[0] = 8'h00;
    @(negedge clk);
    #1;
    rst = 1'b0;
    at_k(140);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
